// File: rtl/demux_packer.sv
// demux_packer: packs a stream of BUS_SIZE-bit slices into one CHANNELS*BUS_SIZE-bit word.
// Optional build macro PACKER_MSB_FIRST_EN: first slice of each word lands in the top slot.

module demux_packer_lane #(
  parameter int BUS_SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                ld,
  input  logic [BUS_SIZE-1:0] d,
  output logic [BUS_SIZE-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
  end
endmodule

module demux_packer #(
  parameter int CHANNELS = 4,
  parameter int BUS_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic [BUS_SIZE-1:0]            in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*BUS_SIZE-1:0]   data_out,
  output logic [$clog2(CHANNELS+1)-1:0]  fill_count
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FW = $clog2(CHANNELS+1);

  typedef enum logic {FILL, FULL} state_t;

  state_t                             state, state_nx;
  logic [IW-1:0]                      idx, idx_nx;
  logic [IW-1:0]                      wr_slot, first_slot;
  logic                               acc, drn, last;
  logic [CHANNELS-1:0]                ld, clr;
  logic [CHANNELS-1:0][BUS_SIZE-1:0]  slot;

  assign in_ready  = (state == FILL) | ((state == FULL) & out_ready);
  assign out_valid = (state == FULL);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign last      = (idx == IW'(CHANNELS-1));

`ifdef PACKER_MSB_FIRST_EN
  assign wr_slot    = IW'(CHANNELS-1) - idx;
  assign first_slot = IW'(CHANNELS-1);
`else
  assign wr_slot    = idx;
  assign first_slot = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (clear) begin
      state_nx = FILL;
      idx_nx   = '0;
    end else begin
      case (state)
        FILL: if (acc) begin
          if (last) begin
            state_nx = FULL;
            idx_nx   = '0;
          end else begin
            idx_nx   = idx + IW'(1);
          end
        end
        FULL: if (drn) begin
          if (acc) begin
            // A one-slot word is complete as soon as its single slice lands.
            if (CHANNELS == 1) begin
              state_nx = FULL;
              idx_nx   = '0;
            end else begin
              state_nx = FILL;
              idx_nx   = IW'(1);
            end
          end else begin
            state_nx = FILL;
            idx_nx   = '0;
          end
        end
        default: begin
          state_nx = FILL;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Draining a full word zeroes every slot except the one taking a same-cycle slice.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    assign ld[k]  = ~clear & acc &
                    (((state == FILL) & (wr_slot == IW'(k))) |
                     ((state == FULL) & (first_slot == IW'(k))));
    assign clr[k] = clear |
                    ((state == FULL) & drn & ~(acc & (first_slot == IW'(k))));

    demux_packer_lane #(.BUS_SIZE(BUS_SIZE)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr[k]),
      .ld    (ld[k]),
      .d     (in_data),
      .q     (slot[k])
    );
  end

  assign data_out   = slot;
  assign fill_count = (state == FULL) ? FW'(CHANNELS) : FW'(idx);

endmodule

// File: tb/tb_demux_packer.sv
// Directed bench for demux_packer: a 4x8 instance plus a 1x8 instance for the single-slot case.
module tb_demux_packer;
  logic        clk = 1'b0;
  logic        reset;
  logic        clear, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid;
  logic [31:0] data_out;
  logic [2:0]  fill_count;

  logic        c1_in_valid, c1_out_ready, c1_in_ready, c1_out_valid;
  logic [7:0]  c1_in_data, c1_data_out;
  logic [0:0]  c1_fill_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_packer #(.CHANNELS(4), .BUS_SIZE(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .fill_count(fill_count)
  );

  demux_packer #(.CHANNELS(1), .BUS_SIZE(8)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(c1_in_valid), .in_data(c1_in_data),
    .in_ready(c1_in_ready), .out_valid(c1_out_valid), .out_ready(c1_out_ready),
    .data_out(c1_data_out), .fill_count(c1_fill_count)
  );

  // Expected word given slices in arrival order (0 for slots not yet written).
  function automatic logic [31:0] pk(input logic [7:0] a, b, c, d);
`ifdef PACKER_MSB_FIRST_EN
    return {a, b, c, d};
`else
    return {d, c, b, a};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    c1_in_valid = 1'b0; c1_in_data = '0; c1_out_ready = 1'b0;
    #12;
    chk("rst_data", data_out, 32'h0);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_fill", fill_count, 3'd0);
    reset = 1'b1;
    tick();
    chk("rel_iready", in_ready, 1'b1);

    // Async reset mid-word.
    send(8'hA1);
    send(8'hA2);
    chk("mid_fill", fill_count, 3'd2);
    chk("mid_data", data_out, pk(8'hA1, 8'hA2, 8'h00, 8'h00));
    #2 reset = 1'b0;
    #1;
    chk("async_data", data_out, 32'h0);
    chk("async_ovalid", out_valid, 1'b0);
    chk("async_fill", fill_count, 3'd0);
    reset = 1'b1;
    #1;
    chk("async_iready", in_ready, 1'b1);
    tick();

    // Full word held while consumer stalls.
    send(8'h11); send(8'h22); send(8'h33);
    chk("lat_ovalid3", out_valid, 1'b0);
    chk("lat_fill3", fill_count, 3'd3);
    send(8'h44);
    chk("full_ovalid", out_valid, 1'b1);
    chk("full_data", data_out, pk(8'h11, 8'h22, 8'h33, 8'h44));
    chk("full_fill", fill_count, 3'd4);
    chk("full_iready", in_ready, 1'b0);
    send(8'h99);
    chk("hold_data", data_out, pk(8'h11, 8'h22, 8'h33, 8'h44));
    chk("hold_ovalid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("drain_iready", in_ready, 1'b1);
    tick();
    chk("drain_ovalid", out_valid, 1'b0);
    chk("drain_data", data_out, 32'h0);
    chk("drain_fill", fill_count, 3'd0);

    // Back-to-back stream with out_ready held.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      chk("stream_iready", in_ready, 1'b1);
      tick();
      if (i == 4) begin
        chk("stream_w0_ov", out_valid, 1'b1);
        chk("stream_w0", data_out, pk(8'h01, 8'h02, 8'h03, 8'h04));
      end
      if (i == 5) chk("stream_w1_part", data_out, pk(8'h05, 8'h00, 8'h00, 8'h00));
      if (i == 8) begin
        chk("stream_w1_ov", out_valid, 1'b1);
        chk("stream_w1", data_out, pk(8'h05, 8'h06, 8'h07, 8'h08));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_fill", fill_count, 3'd0);
    chk("stream_end_ov", out_valid, 1'b0);

    // Drain and accept in the same cycle.
    out_ready = 1'b0;
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    out_ready = 1'b1;
    send(8'hAA);
    out_ready = 1'b0;
    chk("da_data", data_out, pk(8'hAA, 8'h00, 8'h00, 8'h00));
    chk("da_fill", fill_count, 3'd1);
    chk("da_ovalid", out_valid, 1'b0);

    // Clear after three accepts drops the concurrent slice.
    send(8'hB1); send(8'hB2);
    chk("pre_clr_fill", fill_count, 3'd3);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_fill", fill_count, 3'd0);
    chk("clr_data", data_out, 32'h0);
    chk("clr_ovalid", out_valid, 1'b0);
    send(8'h66);
    chk("post_clr_data", data_out, pk(8'h66, 8'h00, 8'h00, 8'h00));
    chk("post_clr_fill", fill_count, 3'd1);

    // Single-slot packer stays full across back-to-back slices.
    c1_out_ready = 1'b1; c1_in_valid = 1'b1; c1_in_data = 8'h5A;
    tick();
    chk("c1_ov0", c1_out_valid, 1'b1);
    chk("c1_d0", c1_data_out, 8'h5A);
    chk("c1_fill0", c1_fill_count, 1'b1);
    chk("c1_iready", c1_in_ready, 1'b1);
    c1_in_data = 8'h5B;
    tick();
    chk("c1_ov1", c1_out_valid, 1'b1);
    chk("c1_d1", c1_data_out, 8'h5B);
    c1_in_valid = 1'b0;
    tick();
    chk("c1_ov2", c1_out_valid, 1'b0);
    chk("c1_fill2", c1_fill_count, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
